multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  7  opcode field of the instruction register; valid from DECODE onward.
REQ-005 funct3  input  3  funct3 field of the instruction register.
REQ-006 funct7_5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 alu_inst  output  4  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or.
REQ-009 alu_src_a  output  2  ALU A select: 00 PC, 01 old PC, 10 rs1.
REQ-010 alu_src_b  output  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4.
REQ-011 result_src  output  2  result mux select: 00 ALU-out register, 01 memory data, 10 ALU result.
REQ-012 adr_src  output  1  memory address select: 0 PC, 1 result.
REQ-013 pc_write, ir_write, reg_write, mem_write  output  1 each  write enables.
REQ-014 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-015 state  output  4  current state code, for debug and verification.

Function
REQ-016 State codes: RESET 0, FETCH 1, DECODE 2, MEMADR 3, MEMREAD 4, MEMWB 5, MEMWRITE 6, EXECR 7, ALUWB 8, EXECI 9, JAL 10, BEQ 11; codes 12-15 SHALL go to FETCH on the next edge.
REQ-017 Every output not listed for a state SHALL be 0 in that state, and alu_inst SHALL default to 0010.
REQ-018 RESET: all enables 0; the next state is always FETCH.
REQ-019 FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, add, result_src=10, pc_write=1; next state DECODE.
REQ-020 DECODE: alu_src_a=01, alu_src_b=01, add.
REQ-021 DECODE next state by opcode: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL.
REQ-022 DECODE with any other opcode: next state FETCH, with illegal_op=1 during that DECODE cycle.
REQ-023 MEMADR: alu_src_a=10, alu_src_b=01, add; next state MEMREAD if opcode=0000011, otherwise MEMWRITE.
REQ-024 MEMREAD: result_src=00, adr_src=1; next state MEMWB.
REQ-025 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-026 MEMWRITE: result_src=00, adr_src=1, mem_write=1; next state FETCH.
REQ-027 EXECR: alu_src_a=10, alu_src_b=00, alu_inst per REQ-031; next state ALUWB.
REQ-028 EXECI: alu_src_a=10, alu_src_b=01, alu_inst per REQ-031; next state ALUWB.
REQ-029 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-030 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1; next state ALUWB.
REQ-031 ALU decode in EXECR/EXECI:
- funct3 000 -> 0110 if EXECR and funct7_5=1, else 0010 (funct7_5 is ignored in EXECI);
- funct3 111 -> 0000;
- funct3 110 -> 0001;
- any other funct3 -> 0010.
REQ-032 BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=zero combinationally in the same cycle; next state FETCH.
REQ-033 State SHALL be registered; outputs SHALL be combinational functions of state, with only pc_write (BEQ) and alu_inst (EXECR/EXECI) also depending on inputs.
REQ-034 Instruction latency in cycles, counted from FETCH inclusive: lw 5, sw 4, R/I 4, jal 4, beq 3, illegal 2.
REQ-035 opcode/funct inputs SHALL be ignored in FETCH and RESET.

Reset
REQ-036 rst_n low SHALL force state=RESET immediately, independent of clk, with all enables 0 while low.
REQ-037 After deassertion, the first rising edge SHALL enter FETCH.
REQ-038 Reset asserted mid-instruction (e.g. during MEMWRITE) SHALL drop mem_write within the same cycle, with no further writes.

Verification
REQ-039 Reset, release, opcode=0110011, funct3=000, funct7_5=1 -> state sequence 0,1,2,7,8,1; alu_inst=0110 in EXECR; reg_write=1 only in ALUWB.
REQ-040 opcode=0000011 -> states 1,2,3,4,5,1; adr_src=1 in MEMREAD; result_src=01 and reg_write=1 in MEMWB.
REQ-041 opcode=1100011 with zero=1 in BEQ -> pc_write=1 in BEQ; repeat with zero=0 -> pc_write=0; both cases return to FETCH.
REQ-042 opcode=0010011, funct3=110, funct7_5=1 -> alu_inst=0001, alu_src_b=01 in EXECI; opcode=0010011, funct3=000, funct7_5=1 -> alu_inst=0010.
REQ-043 opcode=1111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, no write enables asserted.
REQ-044 rst_n pulsed low mid-cycle during MEMWRITE -> mem_write and state drop to 0 asynchronously; FETCH occurs on the first edge after release.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: registered state, combinational datapath controls.
// Only pc_write (branch) and alu_inst (ALU execute states) look at the live inputs.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       zero,
  output logic [3:0] alu_inst,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StReset    = 4'd0,
    StFetch    = 4'd1,
    StDecode   = 4'd2,
    StMemAdr   = 4'd3,
    StMemRead  = 4'd4,
    StMemWb    = 4'd5,
    StMemWrite = 4'd6,
    StExecR    = 4'd7,
    StAluWb    = 4'd8,
    StExecI    = 4'd9,
    StJal      = 4'd10,
    StBeq      = 4'd11
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  state_e     state_q, state_d;
  logic [3:0] alu_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

  // Subtract only for R-type with bit 30 set; addi ignores funct7_5.
  always_comb begin
    alu_dec = AluAdd;
    case (funct3)
      3'b000:  alu_dec = (state_q == StExecR && funct7_5) ? AluSub : AluAdd;
      3'b111:  alu_dec = AluAnd;
      3'b110:  alu_dec = AluOr;
      default: alu_dec = AluAdd;
    endcase
  end

  always_comb begin
    state_d    = StFetch;
    alu_inst   = AluAdd;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    result_src = 2'b00;
    adr_src    = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      StReset: state_d = StFetch;
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBeq;
          OpJal:           state_d = StJal;
          default: begin
            state_d    = StFetch;
            illegal_op = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = StFetch;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_inst  = alu_dec;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_inst  = alu_dec;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = StAluWb;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_inst  = AluSub;
        pc_write  = zero;
        state_d   = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

endmodule
